// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a Mealy match flag and a saturating match counter.
// Revision 1.0 - initial release.
`default_nettype none

module seq_detect_param #(
  parameter int              PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int              OVERLAP = 1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             x,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // The fill counter only has to reach PAT_W-1, so it always fits in clog2(PAT_W) bits.
  localparam int               FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               DISCARD  = (OVERLAP == 0);

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;

  assign window  = {hist, x};
  assign y       = en & ~clr & (fill == FILL_MAX) & (window == PATTERN);
  assign cnt_sat = (match_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (clr) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (en) begin
      hist <= window[PAT_W-2:0];
      // Non-overlapping mode forgets the history so the next match needs PAT_W fresh bits.
      if (y && DISCARD) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FW'(1);
      end
      if (y && !cnt_sat) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameterisations driven from one shared stimulus stream.
`default_nettype none

module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst, en, clr, x;
  logic y0, y1, y2, y3;
  logic s0, s1, s2, s3;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detect_param d0 (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                       .y(y0), .match_cnt(c0), .cnt_sat(s0));
  seq_detect_param #(.OVERLAP(0)) d1 (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                       .y(y1), .match_cnt(c1), .cnt_sat(s1));
  seq_detect_param #(.CNT_W(2)) d2 (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                       .y(y2), .match_cnt(c2), .cnt_sat(s2));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1)) d3 (.clk(clk), .rst(rst),
                       .en(en), .clr(clr), .x(x), .y(y3), .match_cnt(c3), .cnt_sat(s3));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; y is checked 1 ns later, before the next rising edge.
  task automatic drive(input logic xi, input logic eni, input logic clri);
    @(negedge clk);
    x = xi; en = eni; clr = clri;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; x = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0;
    #12;
    chk("reset_y", y0, 0);
    chk("reset_cnt", c0, 0);
    chk("reset_sat", s0, 0);
    rst = 1'b1;

    // Overlapping vs non-overlapping on 1,0,1,0,1
    drive(1, 1, 0); chk("ov_b1_y", y0, 0); tick();
    drive(0, 1, 0); chk("ov_b2_y", y0, 0); tick();
    drive(1, 1, 0); chk("ov_b3_y", y0, 1); chk("nov_b3_y", y1, 1); tick();
    drive(0, 1, 0); chk("ov_b4_y", y0, 0); chk("nov_b4_y", y1, 0); tick();
    drive(1, 1, 0); chk("ov_b5_y", y0, 1); chk("nov_b5_y", y1, 0); tick();
    chk("ov_cnt", c0, 2);
    chk("nov_cnt", c1, 1);

    // Saturation with a 2-bit counter; async reset clears the count of 2 left from above
    @(negedge clk);
    en = 1'b0; rst = 1'b0;
    #1;
    chk("async_rst_cnt", c2, 0);
    chk("async_rst_sat", s2, 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(((i % 2) == 0) ? 1'b1 : 1'b0, 1, 0);
      if (i == 8) chk("sat_b9_y", y2, 1);
      tick();
      if (i == 4) begin
        chk("sat_cnt_m2", c2, 2);
        chk("sat_flag_m2", s2, 0);
      end
      if (i == 6) begin
        chk("sat_cnt_m3", c2, 3);
        chk("sat_flag_m3", s2, 1);
      end
    end
    chk("sat_cnt_m4", c2, 3);
    chk("sat_flag_m4", s2, 1);

    // en=0 cycles must neither shift history nor raise y
    rst_pulse();
    drive(1, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0); chk($sformatf("en0_c%0d_y", i), y0, 0); tick();
    end
    drive(0, 1, 0); chk("en_b2_y", y0, 0); tick();
    drive(1, 1, 0); chk("en_b3_y", y0, 1); tick();
    chk("en_cnt", c0, 1);
    drive(0, 1, 0); tick();
    drive(1, 0, 0); chk("en0_full_y", y0, 0); tick();
    drive(1, 1, 0); chk("en_resume_y", y0, 1); tick();
    chk("en_cnt2", c0, 2);

    // Reset between partial-pattern bits discards them
    rst_pulse();
    drive(1, 1, 0); tick();
    drive(0, 1, 0); tick();
    rst_pulse();
    drive(1, 1, 0); chk("rst_mid_y", y0, 0); tick();
    chk("rst_mid_cnt", c0, 0);

    // Synchronous clear does the same and also zeroes the counter
    rst_pulse();
    drive(1, 1, 0); tick();
    drive(0, 1, 0); tick();
    drive(1, 1, 0); tick();
    chk("clr_pre_cnt", c0, 1);
    drive(0, 1, 0); tick();
    drive(1, 1, 1); chk("clr_cycle_y", y0, 0); tick();
    chk("clr_cnt", c0, 0);
    drive(0, 1, 0); chk("clr_after1_y", y0, 0); tick();
    drive(1, 1, 0); chk("clr_after2_y", y0, 0); tick();
    chk("clr_after_cnt", c0, 0);

    // 4-bit pattern 1101 with overlap on 1,1,0,1,1,0,1
    rst_pulse();
    drive(1, 1, 0); chk("p4_b1_y", y3, 0); tick();
    drive(1, 1, 0); chk("p4_b2_y", y3, 0); tick();
    drive(0, 1, 0); chk("p4_b3_y", y3, 0); tick();
    drive(1, 1, 0); chk("p4_b4_y", y3, 1); tick();
    drive(1, 1, 0); chk("p4_b5_y", y3, 0); tick();
    drive(0, 1, 0); chk("p4_b6_y", y3, 0); tick();
    drive(1, 1, 0); chk("p4_b7_y", y3, 1); tick();
    chk("p4_cnt", c3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
